data_break_ctrl: RTL

- CPU-side responder for the single-word data-break (DMA) channel used by the RK8E and future break devices.
- Samples a device's data_break request at a CPU major-state boundary and stalls the CPU.
- Runs one memory cycle: device-to-memory write, or memory-to-device read when to_disk=1.
- Signals completion with break_in_prog, and returns read data to the device.
- Sits between the disk controller, the CPU state sequencer and the 32K-word memory block.

---
 rtl/data_break_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/data_break_ctrl.sv
// rtl/data_break_ctrl.sv - single-word data-break (DMA) responder; define DB_LATE_EN for the late-request flag
`timescale 1ns/1ps
module data_break_ctrl #(
   parameter int LATE_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        data_break,
   input  logic        to_disk,
   input  logic [0:14] dmaAddr,
   input  logic [0:11] dmaDOUT,
   input  logic        break_ok,
   output logic        cpu_hold,
   output logic        break_in_prog,
   output logic [0:11] dmaDIN,
   output logic        din_valid,
   output logic [0:14] mem_addr,
   output logic [0:11] mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic [0:11] mem_rdata,
   output logic        data_late
);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_END} state_e;

   state_e      state;
   state_e      state_nxt;
   logic        accept;
   logic [0:14] addr_q;
   logic [0:11] wdata_q;
   logic        rd_q;

   logic        hold_d;
   logic        bip_d;
   logic        rd_d;
   logic        wr_d;
   logic        dv_d;
   logic [0:14] addr_d;
   logic [0:11] wdata_d;

   assign accept = (state == S_IDLE) && data_break && break_ok && !clear;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_ADDR;
         S_ADDR:  state_nxt = S_DATA;
         S_DATA:  state_nxt = S_END;
         S_END:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Request is captured once; later changes on the device bus are ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
      end else if (accept) begin
         addr_q  <= dmaAddr;
         wdata_q <= dmaDOUT;
         rd_q    <= to_disk;
      end
   end

   always_comb begin
      hold_d  = 1'b0;
      bip_d   = 1'b0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      dv_d    = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      case (state)
         S_ADDR: begin
            hold_d  = 1'b1;
            bip_d   = 1'b1;
            addr_d  = addr_q;
            rd_d    = rd_q;
            wr_d    = !rd_q;
            wdata_d = rd_q ? '0 : wdata_q;
         end
         S_DATA: begin
            hold_d = 1'b1;
            bip_d  = 1'b1;
         end
         S_END: begin
            hold_d = 1'b1;
            dv_d   = rd_q;
         end
         default: ;
      endcase
   end

   // Memory returns read data one cycle after mem_rd, so it is captured while in END.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_hold      <= 1'b0;
         break_in_prog <= 1'b0;
         mem_rd        <= 1'b0;
         mem_wr        <= 1'b0;
         din_valid     <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         dmaDIN        <= '0;
      end else begin
         cpu_hold      <= hold_d;
         break_in_prog <= bip_d;
         mem_rd        <= rd_d;
         mem_wr        <= wr_d;
         din_valid     <= dv_d;
         mem_addr      <= addr_d;
         mem_wdata     <= wdata_d;
         if (state == S_END && rd_q) begin
            dmaDIN <= mem_rdata;
         end
      end
   end

`ifdef DB_LATE_EN
   logic [6:0] late_cnt;
   logic       late_q;
   logic       waiting;

   assign waiting = (state == S_IDLE) && data_break && !break_ok;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         late_cnt <= '0;
         late_q   <= 1'b0;
      end else begin
         if (waiting) begin
            late_cnt <= (late_cnt == 7'h7f) ? late_cnt : late_cnt + 7'd1;
         end else if (!data_break || accept) begin
            late_cnt <= '0;
         end
         if (clear) begin
            late_q <= 1'b0;
         end else if (waiting && (int'(late_cnt) + 1 >= LATE_CYCLES)) begin
            late_q <= 1'b1;
         end
      end
   end

   assign data_late = late_q;
`else
   // No late detection in this build; LATE_CYCLES is accepted but has no effect.
   assign data_late = 1'b0 & (LATE_CYCLES != 0);
`endif

endmodule
